// File: rtl/poly_pkg.sv
// Shared types, FSM encodings and datapath widths for the polygon classifier.
// Winding support in the top is selected by POLYGON_CLASSIFIER_WINDING_EN.
package poly_pkg;

  localparam int WORLD_BITS_DEF = 32;

  typedef logic signed [WORLD_BITS_DEF-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } vertex_t;

  typedef enum logic {
    EVEN_ODD = 1'b0,
    NONZERO  = 1'b1
  } fill_rule_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } classifier_state_e;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Coordinate differences, their products and the cross product never truncate.
  function automatic int diff_w(input int wb);
    return wb + 1;
  endfunction

  function automatic int prod_w(input int wb);
    return 2 * wb + 2;
  endfunction

  function automatic int cross_w(input int wb);
    return 2 * wb + 3;
  endfunction

endpackage

// File: rtl/edge_crossing_lane.sv
// One edge-vs-point lane: registers both cross-product terms and the y-span test, 1-cycle latency.
// Free-running pipeline stage with no backpressure; a disabled lane reports no crossing.
module edge_crossing_lane
  import poly_pkg::*;
#(
  parameter int WORLD_BITS = 32
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic                         en_in,
  input  logic                         up_in,
  input  logic signed [WORLD_BITS-1:0] h_x_in,
  input  logic signed [WORLD_BITS-1:0] h_y_in,
  input  logic signed [WORLD_BITS-1:0] l_x_in,
  input  logic signed [WORLD_BITS-1:0] l_y_in,
  input  logic signed [WORLD_BITS-1:0] x_in,
  input  logic signed [WORLD_BITS-1:0] y_in,
  output logic                         cross_out,
  output logic                         dir_out
);

  localparam int DW = diff_w(WORLD_BITS);
  localparam int PW = prod_w(WORLD_BITS);
  localparam int CW = cross_w(WORLD_BITS);

  logic signed [DW-1:0] d_lhx, d_yhy, d_lhy, d_xhx;
  logic signed [PW-1:0] p_a_d, p_a_q, p_b_d, p_b_q;
  logic signed [CW-1:0] c;
  logic                 span_d, span_q, dir_d, dir_q;

  always_comb begin
    d_lhx  = $signed({l_x_in[WORLD_BITS-1], l_x_in}) - $signed({h_x_in[WORLD_BITS-1], h_x_in});
    d_yhy  = $signed({y_in[WORLD_BITS-1], y_in}) - $signed({h_y_in[WORLD_BITS-1], h_y_in});
    d_lhy  = $signed({l_y_in[WORLD_BITS-1], l_y_in}) - $signed({h_y_in[WORLD_BITS-1], h_y_in});
    d_xhx  = $signed({x_in[WORLD_BITS-1], x_in}) - $signed({h_x_in[WORLD_BITS-1], h_x_in});
    p_a_d  = $signed({{(PW-DW){d_lhx[DW-1]}}, d_lhx}) * $signed({{(PW-DW){d_yhy[DW-1]}}, d_yhy});
    p_b_d  = $signed({{(PW-DW){d_lhy[DW-1]}}, d_lhy}) * $signed({{(PW-DW){d_xhx[DW-1]}}, d_xhx});
    span_d = en_in && (h_y_in > y_in) && (y_in >= l_y_in);
    dir_d  = up_in;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      p_a_q  <= '0;
      p_b_q  <= '0;
      span_q <= 1'b0;
      dir_q  <= 1'b0;
    end else begin
      p_a_q  <= p_a_d;
      p_b_q  <= p_b_d;
      span_q <= span_d;
      dir_q  <= dir_d;
    end
  end

  assign c         = $signed({p_a_q[PW-1], p_a_q}) - $signed({p_b_q[PW-1], p_b_q});
  assign cross_out = span_q && (c[CW-1] || (c == '0));
  assign dir_out   = dir_q;

endmodule

// File: rtl/polygon_classifier.sv
// Point-in-polygon classifier, LANES edges/cycle; verdict K+3 cycles after accept (1 cycle when n<3).
// ready_out low from accept until the result is taken; result held while ready_in low. Winding: POLYGON_CLASSIFIER_WINDING_EN.
module polygon_classifier
  import poly_pkg::*;
#(
  parameter int WORLD_BITS       = 32,
  parameter int MAX_NUM_VERTICES = 32,
  parameter int LANES            = 4
) (
  input  logic                                      clk_in,
  input  logic                                      rst_n_in,
  input  logic                                      valid_in,
  output logic                                      ready_out,
  input  logic signed [WORLD_BITS-1:0]              x_in,
  input  logic signed [WORLD_BITS-1:0]              y_in,
  input  logic signed [WORLD_BITS-1:0]              poly_xs_in [MAX_NUM_VERTICES],
  input  logic signed [WORLD_BITS-1:0]              poly_ys_in [MAX_NUM_VERTICES],
  input  logic [$clog2(MAX_NUM_VERTICES+1)-1:0]     num_points_in,
  input  logic                                      nonzero_in,
  output logic                                      valid_out,
  input  logic                                      ready_in,
  output logic                                      inside_out,
  output logic signed [$clog2(MAX_NUM_VERTICES+1):0] winding_out
);

  localparam int NW = $clog2(MAX_NUM_VERTICES + 1);
  localparam int WW = NW + 1;
  localparam int IW = $clog2(MAX_NUM_VERTICES);

  typedef logic signed [WORLD_BITS-1:0] crd_t;

  logic [1:0]       state_q, state_d;
  logic [NW-1:0]    n_q, n_d, grp_q, grp_d, n_clamp;
  crd_t             x_q, x_d, y_q, y_d;
  crd_t             vx_q [MAX_NUM_VERTICES];
  crd_t             vx_d [MAX_NUM_VERTICES];
  crd_t             vy_q [MAX_NUM_VERTICES];
  crd_t             vy_d [MAX_NUM_VERTICES];
  logic             parity_q, parity_d, inside_q, inside_d;
  logic             accept, last_grp;
  logic [LANES-1:0] lane_en, lane_up, lane_cross, lane_dir;
  crd_t             h_x [LANES];
  crd_t             h_y [LANES];
  crd_t             l_x [LANES];
  crd_t             l_y [LANES];
  crd_t             ax, ay, bx, by;
  int               idx, nxt;

  assign ready_out = rst_n_in && (state_q == ST_IDLE);
  assign valid_out = (state_q == ST_DONE);
  assign accept    = valid_in && ready_out;
  assign n_clamp   = (num_points_in > NW'(MAX_NUM_VERTICES)) ? NW'(MAX_NUM_VERTICES) : num_points_in;
  assign last_grp  = ((int'(grp_q) + 1) * LANES) >= int'(n_q);

  // Edge idx joins v[idx] to v[idx+1], wrapping to v[0] on the last edge; equal y picks the far end as H.
  always_comb begin
    lane_en = '0;
    lane_up = '0;
    ax = '0; ay = '0; bx = '0; by = '0;
    idx = 0;
    nxt = 0;
    for (int j = 0; j < LANES; j++) begin
      idx = int'(grp_q) * LANES + j;
      nxt = ((idx + 1) >= int'(n_q)) ? 0 : idx + 1;
      ax  = vx_q[IW'(idx)];
      ay  = vy_q[IW'(idx)];
      bx  = vx_q[IW'(nxt)];
      by  = vy_q[IW'(nxt)];
      if (ay > by) begin
        h_x[j] = ax; h_y[j] = ay; l_x[j] = bx; l_y[j] = by;
      end else begin
        h_x[j] = bx; h_y[j] = by; l_x[j] = ax; l_y[j] = ay;
      end
      lane_up[j] = (ay < by);
      lane_en[j] = (state_q == ST_SCAN) && (idx < int'(n_q));
    end
  end

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    edge_crossing_lane #(.WORLD_BITS(WORLD_BITS)) u_lane (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .en_in     (lane_en[j]),
      .up_in     (lane_up[j]),
      .h_x_in    (h_x[j]),
      .h_y_in    (h_y[j]),
      .l_x_in    (l_x[j]),
      .l_y_in    (l_y[j]),
      .x_in      (x_q),
      .y_in      (y_q),
      .cross_out (lane_cross[j]),
      .dir_out   (lane_dir[j])
    );
  end

`ifdef POLYGON_CLASSIFIER_WINDING_EN
  localparam logic signed [WW-1:0] W_POS = {{(WW-1){1'b0}}, 1'b1};
  localparam logic signed [WW-1:0] W_NEG = {WW{1'b1}};
  fill_rule_e            rule_q, rule_d;
  logic signed [WW-1:0]  wind_acc_q, wind_acc_d, wind_out_q, wind_out_d;
  assign winding_out = wind_out_q;
`else
  logic unused_winding;
  assign unused_winding = ^{nonzero_in, lane_dir};
  assign winding_out    = '0;
`endif

  always_comb begin
    state_d  = state_q;
    grp_d    = grp_q;
    n_d      = n_q;
    x_d      = x_q;
    y_d      = y_q;
    vx_d     = vx_q;
    vy_d     = vy_q;
    parity_d = parity_q ^ (^lane_cross);
    inside_d = inside_q;
`ifdef POLYGON_CLASSIFIER_WINDING_EN
    rule_d     = rule_q;
    wind_out_d = wind_out_q;
    wind_acc_d = wind_acc_q;
    for (int j = 0; j < LANES; j++) begin
      if (lane_cross[j]) wind_acc_d = wind_acc_d + (lane_dir[j] ? W_POS : W_NEG);
    end
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          x_d      = x_in;
          y_d      = y_in;
          vx_d     = poly_xs_in;
          vy_d     = poly_ys_in;
          n_d      = n_clamp;
          grp_d    = '0;
          parity_d = 1'b0;
          inside_d = 1'b0;
`ifdef POLYGON_CLASSIFIER_WINDING_EN
          rule_d     = fill_rule_e'(nonzero_in);
          wind_acc_d = '0;
          wind_out_d = '0;
`endif
          state_d  = (n_clamp < NW'(3)) ? ST_DONE : ST_SCAN;
        end
      end
      ST_SCAN: begin
        grp_d = grp_q + 1'b1;
        if (last_grp) begin
          grp_d   = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        grp_d = grp_q + 1'b1;
        // Second drain cycle: the last group has been accumulated, so the verdict is final.
        if (grp_q[0]) begin
          grp_d   = '0;
          state_d = ST_DONE;
`ifdef POLYGON_CLASSIFIER_WINDING_EN
          inside_d   = (rule_q == NONZERO) ? (wind_acc_q != '0) : parity_q;
          wind_out_d = wind_acc_q;
`else
          inside_d   = parity_q;
`endif
        end
      end
      ST_DONE: begin
        if (ready_in) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= ST_IDLE;
      grp_q    <= '0;
      n_q      <= '0;
      x_q      <= '0;
      y_q      <= '0;
      parity_q <= 1'b0;
      inside_q <= 1'b0;
      for (int i = 0; i < MAX_NUM_VERTICES; i++) begin
        vx_q[i] <= '0;
        vy_q[i] <= '0;
      end
`ifdef POLYGON_CLASSIFIER_WINDING_EN
      rule_q     <= EVEN_ODD;
      wind_acc_q <= '0;
      wind_out_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      grp_q    <= grp_d;
      n_q      <= n_d;
      x_q      <= x_d;
      y_q      <= y_d;
      parity_q <= parity_d;
      inside_q <= inside_d;
      vx_q     <= vx_d;
      vy_q     <= vy_d;
`ifdef POLYGON_CLASSIFIER_WINDING_EN
      rule_q     <= rule_d;
      wind_acc_q <= wind_acc_d;
      wind_out_q <= wind_out_d;
`endif
    end
  end

  assign inside_out = inside_q;

endmodule

// File: doc/polygon_classifier.md
# polygon_classifier

Multi-cycle, handshaked point-in-polygon classifier: successor to the fully parallel containment tester. It latches a query point plus a vertex list, evaluates `LANES` edges per cycle against the point, and returns a registered inside/outside verdict under an even-odd or nonzero-winding fill rule. It sits between the world-geometry store and the renderer/collision logic, and trades latency for multiplier count when `MAX_NUM_VERTICES` is large.

## Interface

**Parameters**
- `WORLD_BITS`, default 32: signed coordinate width.
- `MAX_NUM_VERTICES`, default 32: vertex storage depth.
- `LANES`, default 4: edges evaluated per cycle. Must divide `MAX_NUM_VERTICES`.

**Ports**
- `clk_in`, input, 1: the single clock.
- `rst_n_in`, input, 1: asynchronous, active-low reset.
- `valid_in`, input, 1: query request.
- `ready_out`, output, 1: block can accept a query.
- `x_in`, `y_in`, input, `WORLD_BITS` signed: query point.
- `poly_xs_in`, `poly_ys_in`, input, `WORLD_BITS` signed × `MAX_NUM_VERTICES`: vertex arrays.
- `num_points_in`, input, `$clog2(MAX_NUM_VERTICES+1)`: vertex count.
- `nonzero_in`, input, 1: fill rule. 0 selects even-odd; 1 selects nonzero winding.
- `valid_out`, output, 1: result available.
- `ready_in`, input, 1: consumer takes the result.
- `inside_out`, output, 1: verdict.
- `winding_out`, output, `$clog2(MAX_NUM_VERTICES+1)+1` signed: signed crossing count.

## Operation

**Accept.** A query is accepted when `valid_in && ready_out`. On accept the block latches the point, all vertices, `nonzero_in`, and n = min(`num_points_in`, `MAX_NUM_VERTICES`). Inputs may change freely after accept.

**Edges.** Edge i runs from v[i] to v[(i+1) mod n], for i < n. For each edge, H is the endpoint with the greater y and L is the other endpoint (ties go to v[(i+1) mod n] as H).

**Crossing test.**
- Cross product: c = (Lx−Hx)(y−Hy) − (Ly−Hy)(x−Hx).
- Width rules: differences are `WORLD_BITS`+1 bits, products 2·`WORLD_BITS`+2 bits, c is 2·`WORLD_BITS`+3 bits. Full precision throughout, no truncation.
- An edge crosses when Hy > y ≥ Ly and c ≤ 0.
- Sign of a crossing: +1 if v[i].y < v[(i+1) mod n].y, otherwise −1.

**Accumulation.** A parity bit is XORed once per crossing. The winding counter adds the crossing sign.

**Verdict.** `inside_out` is the parity bit in even-odd mode, or (winding ≠ 0) in nonzero mode.

**Degenerate polygons.** For n < 3 there is no scan. The result is `inside_out`=0 and `winding_out`=0.

**FSM states**
- IDLE: `ready_out`=1. Goes to SCAN on accept, or to DONE on accept when n < 3.
- SCAN: issues edge group k = 0…K−1, where K = ceil(n/`LANES`). Lanes with edge index ≥ n contribute nothing. Goes to DRAIN after group K−1.
- DRAIN: two cycles that flush the product and accumulate stages. Then goes to DONE.
- DONE: `valid_out`=1 with stable outputs. Goes to IDLE when `ready_in`=1.

**Handshake rules**
- `ready_out`=0 in every state except IDLE.
- Once `valid_out` is high, it and its outputs hold until `ready_in` is sampled high.

**Reset.** Assertion at any time, including mid-scan, immediately clears the FSM to IDLE, and clears `valid_out`, `inside_out`, `winding_out`, the accumulators and the latched data to 0. `ready_out` is 0 while reset is asserted and 1 from the first cycle after reset is released.

## Timing

- Accept on cycle T. Group k is issued at T+1+k. Its products and in-bounds flags are registered at T+2+k. The group is accumulated at T+3+k.
- `valid_out` rises at T+K+3.
- For n < 3, `valid_out` rises at T+1.
- The result is consumed at cycle R (`valid_out && ready_in`). `ready_out`=1 at R+1; the next accept is possible at R+1.
- Throughput: one query per K+4 cycles, with `ready_in` tied high.

## Configuration

- Macro: `POLYGON_CLASSIFIER_WINDING_EN`.
- **Defined:** the signed winding counter, `nonzero_in` and `winding_out` behave as specified.
- **Undefined:**
  - Only the parity bit exists; even-odd mode always applies.
  - `nonzero_in` is ignored and `winding_out` is tied to 0.
  - Timing is unchanged.

## Structure

**Package `poly_pkg`**
- `coord_t` (signed `WORLD_BITS`).
- `vertex_t` struct {x, y}.
- `fill_rule_e` {EVEN_ODD, NONZERO}.
- `classifier_state_e` {IDLE, SCAN, DRAIN, DONE}.
- Width constants for products and the cross product.

**Sub-module `edge_crossing_lane`**
- One registered stage.
- Inputs: H, L, point, lane-enable.
- Outputs: `cross_out` (crossing flag) and `dir_out` (crossing sign).
- Instantiated `LANES` times.

## Test plan

1. Square (0,0),(10,0),(10,10),(0,10), point (5,5), `LANES`=4, `ready_in`=1: `valid_out` at T+4, `inside_out`=1, `winding_out`=±1.
2. Same square, points (15,5), (0,5), (10,5): `inside_out`=0, 0, 1 respectively. The left boundary is outside and the right boundary is inside.
3. Pentagram (0,10),(6,−8),(−10,4),(10,4),(−6,−8), point (0,0):
   - even-odd gives `inside_out`=0;
   - nonzero gives `inside_out`=1 with |`winding_out`|=2;
   - with the macro undefined, both modes give 0.
4. 32-vertex polygon, `LANES`=4: `valid_out` at T+11. Hold `ready_in`=0 for 5 cycles: outputs stay stable and `ready_out`=0. Drop `valid_in` and `ready_in` low at the first consume (R), then re-assert `valid_in` from R+1: accept occurs at R+1.
5. `num_points_in`=2, and `num_points_in`=40 (clamped to 32): the first returns 0 at T+1; the second matches the 32-vertex result.
6. Assert `rst_n_in` low during SCAN: outputs are 0 and the FSM returns to IDLE; `ready_out` is 1 on the first cycle after release. A fresh query then returns a correct result.
